// File: rtl/crossbar_ctrl.sv
// Sequencer that turns host commands into registered crossbar line/strobe patterns and returns one response per command.
// Optional FORM_ALL support is built only when CROSSBAR_CTRL_FORM_EN is defined; otherwise op 2 is rejected as illegal.
module crossbar_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_row,
  input  logic [7:0] cmd_data,
  output logic [7:0] bitline,
  output logic [7:0] wordline,
  output logic [7:0] selectline,
  output logic       wenable,
  output logic       form,
  output logic       mac,
  input  logic [7:0] xbar_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  typedef enum logic [2:0] {
    IDLE, WR_DRIVE, MAC_DRIVE, MAC_SAMPLE, FORM_ROW, GAP, RESP
  } state_t;

  state_t     state, state_nx;
  logic [7:0] bl_nx, wl_nx, sl_nx, rsp_data_nx;
  logic       wen_nx, mac_nx, rsp_err_nx;
`ifdef CROSSBAR_CTRL_FORM_EN
  logic [2:0] row_cnt, row_cnt_nx;
  logic       form_nx;
`endif

  // Outputs are registered, so the next line pattern is decided alongside the next state.
  always_comb begin
    state_nx    = state;
    bl_nx       = '0;
    wl_nx       = '0;
    sl_nx       = '0;
    wen_nx      = 1'b0;
    mac_nx      = 1'b0;
    rsp_data_nx = rsp_data;
    rsp_err_nx  = rsp_err;
`ifdef CROSSBAR_CTRL_FORM_EN
    row_cnt_nx  = row_cnt;
    form_nx     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            2'd0: begin
              state_nx = WR_DRIVE;
              wl_nx    = 8'd1 << cmd_row;
              bl_nx    = cmd_data;
              sl_nx    = ~cmd_data;
              wen_nx   = 1'b1;
            end
            2'd1: begin
              state_nx = MAC_DRIVE;
              wl_nx    = cmd_data;
              mac_nx   = 1'b1;
            end
`ifdef CROSSBAR_CTRL_FORM_EN
            2'd2: begin
              state_nx   = FORM_ROW;
              row_cnt_nx = 3'd0;
              wl_nx      = 8'h01;
              bl_nx      = 8'hFF;
              form_nx    = 1'b1;
            end
`endif
            default: begin
              state_nx    = RESP;
              rsp_err_nx  = 1'b1;
              rsp_data_nx = 8'h00;
            end
          endcase
        end
      end
      WR_DRIVE:  state_nx = GAP;
      MAC_DRIVE: state_nx = MAC_SAMPLE;
      MAC_SAMPLE: begin
        state_nx    = RESP;
        rsp_data_nx = xbar_out;
        rsp_err_nx  = 1'b0;
      end
`ifdef CROSSBAR_CTRL_FORM_EN
      FORM_ROW: begin
        if (row_cnt == 3'd7) begin
          state_nx   = GAP;
          row_cnt_nx = 3'd0;
        end else begin
          row_cnt_nx = row_cnt + 3'd1;
          wl_nx      = 8'd1 << (row_cnt + 3'd1);
          bl_nx      = 8'hFF;
          form_nx    = 1'b1;
        end
      end
`endif
      GAP: begin
        state_nx    = RESP;
        rsp_data_nx = 8'h00;
        rsp_err_nx  = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx    = IDLE;
          rsp_data_nx = 8'h00;
          rsp_err_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      bitline    <= '0;
      wordline   <= '0;
      selectline <= '0;
      wenable    <= 1'b0;
      mac        <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cmd_ready  <= (state_nx == IDLE);
      bitline    <= bl_nx;
      wordline   <= wl_nx;
      selectline <= sl_nx;
      wenable    <= wen_nx;
      mac        <= mac_nx;
      rsp_valid  <= (state_nx == RESP);
      rsp_data   <= rsp_data_nx;
      rsp_err    <= rsp_err_nx;
    end
  end

`ifdef CROSSBAR_CTRL_FORM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= 3'd0;
      form    <= 1'b0;
    end else begin
      row_cnt <= row_cnt_nx;
      form    <= form_nx;
    end
  end
`else
  assign form = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_ctrl.sv
// Bench for crossbar_ctrl: queue-based command model compared every cycle, plus directed literal checks.
module tb_crossbar_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_row;
  logic [7:0] cmd_data;
  logic [7:0] bitline, wordline, selectline;
  logic       wenable, form, mac;
  logic [7:0] xbar_out;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  crossbar_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_data(cmd_data),
    .bitline(bitline), .wordline(wordline), .selectline(selectline),
    .wenable(wenable), .form(form), .mac(mac),
    .xbar_out(xbar_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a command expands into a list of line frames, followed by a response held until taken.
  typedef struct packed {
    logic [7:0] wl, bl, sl;
    logic       wen, frm, mc;
  } frame_t;

  function automatic frame_t mk(input logic [7:0] wl, bl, sl, input logic wen, frm, mc);
    frame_t f;
    f.wl = wl; f.bl = bl; f.sl = sl; f.wen = wen; f.frm = frm; f.mc = mc;
    return f;
  endfunction

  frame_t     m_frame = '0;
  frame_t     m_pend[$];
  int         m_phase = 0;
  logic       m_ready = 1'b0, m_rv = 1'b0, m_err = 1'b0, m_from_xb = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_pend.delete(); m_frame = '0;
      m_ready = 1'b0; m_rv = 1'b0; m_data = 8'h00; m_err = 1'b0; m_from_xb = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_frame = '0;
          if (m_ready && cmd_valid) begin
            m_err = 1'b0; m_from_xb = 1'b0;
            case (cmd_op)
              2'd0: begin
                m_pend.push_back(mk(8'h01 << cmd_row, cmd_data, ~cmd_data, 1'b1, 1'b0, 1'b0));
                m_pend.push_back('0);
              end
              2'd1: begin
                m_pend.push_back(mk(cmd_data, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
                m_pend.push_back('0);
                m_from_xb = 1'b1;
              end
`ifdef CROSSBAR_CTRL_FORM_EN
              2'd2: begin
                for (int r = 0; r < 8; r++)
                  m_pend.push_back(mk(8'h01 << r, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0));
                m_pend.push_back('0);
              end
`endif
              default: m_err = 1'b1;
            endcase
            if (m_pend.size() == 0) begin
              m_phase = 2; m_rv = 1'b1; m_data = 8'h00;
            end else begin
              m_phase = 1; m_frame = m_pend.pop_front();
            end
          end
          m_ready = (m_phase == 0);
        end
        1: begin
          if (m_pend.size() > 0) m_frame = m_pend.pop_front();
          else begin
            m_frame = '0; m_phase = 2; m_rv = 1'b1;
            m_data = m_from_xb ? xbar_out : 8'h00;
          end
        end
        default: begin
          if (rsp_ready) begin
            m_rv = 1'b0; m_data = 8'h00; m_err = 1'b0; m_phase = 0; m_ready = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("lines", {wordline, bitline, selectline, wenable, form, mac}, m_frame);
    check("handshake", {cmd_ready, rsp_valid, rsp_err, rsp_data}, {m_ready, m_rv, m_err, m_data});
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] row, input logic [7:0] data, output int acc);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("issue_ready", cmd_ready, 1'b1);
    cmd_op = op; cmd_row = row; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0; cmd_data = ~data; cmd_row = row + 3'd1; cmd_op = op ^ 2'd1;
  endtask

  task automatic wait_rsp(input int acc, input int lat, input logic [7:0] data, input logic err, input int hold);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("rsp_latency", cyc - acc + 1, lat);
    check("rsp_data", rsp_data, data);
    check("rsp_err", rsp_err, err);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'd0;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, data);
      check("hold_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_taken", rsp_valid, 1'b0);
    check("idle_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [7:0] exp_wl;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row = 3'd0; cmd_data = 8'h00;
    xbar_out = 8'h00; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {cmd_ready, rsp_valid, rsp_err, rsp_data, wordline, bitline, selectline}, 36'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);

    // WRITE_ROW row 5, data A5
    issue(2'd0, 3'd5, 8'hA5, acc);
    check("wr_drive", {wordline, bitline, selectline, wenable, form, mac}, {8'h20, 8'hA5, 8'h5A, 3'b100});
    @(negedge clk);
    check("wr_gap", {wordline, bitline, selectline, wenable}, 25'h0);
    wait_rsp(acc, 3, 8'h00, 1'b0, 0);

    // WRITE_ROW boundary rows
    issue(2'd0, 3'd0, 8'h01, acc);
    check("wr_row0", {wordline, bitline, selectline}, {8'h01, 8'h01, 8'hFE});
    wait_rsp(acc, 3, 8'h00, 1'b0, 0);
    issue(2'd0, 3'd7, 8'h80, acc);
    check("wr_row7", {wordline, bitline, selectline}, {8'h80, 8'h80, 8'h7F});
    wait_rsp(acc, 3, 8'h00, 1'b0, 0);

    // MAC with xbar_out valid only during MAC_SAMPLE
    issue(2'd1, 3'd0, 8'hFF, acc);
    check("mac_drive", {wordline, bitline, selectline, mac, wenable}, {8'hFF, 16'h0, 2'b10});
    xbar_out = 8'h99;
    @(negedge clk);
    check("mac_sample", {wordline, mac}, 9'h0);
    xbar_out = 8'h3C;
    @(negedge clk);
    xbar_out = 8'h66;
    wait_rsp(acc, 3, 8'h3C, 1'b0, 0);

    // Illegal op
    issue(2'd3, 3'd2, 8'h55, acc);
    check("illegal_lines", {wordline, bitline, selectline, wenable, form, mac}, 27'h0);
    wait_rsp(acc, 1, 8'h00, 1'b1, 0);

    // Response backpressure with a competing command
    issue(2'd0, 3'd2, 8'h3C, acc);
    wait_rsp(acc, 3, 8'h00, 1'b0, 4);

`ifdef CROSSBAR_CTRL_FORM_EN
    issue(2'd2, 3'd0, 8'h00, acc);
    for (int r = 0; r < 8; r++) begin
      exp_wl = 8'h01 << r;
      check("form_row", {wordline, bitline, selectline, form}, {exp_wl, 8'hFF, 8'h00, 1'b1});
      @(negedge clk);
    end
    wait_rsp(acc, 10, 8'h00, 1'b0, 0);
    issue(2'd2, 3'd0, 8'h00, acc);
    repeat (3) @(negedge clk);
    check("form_row3", wordline, 8'h08);
`else
    issue(2'd2, 3'd0, 8'h00, acc);
    check("form_disabled", form, 1'b0);
    wait_rsp(acc, 1, 8'h00, 1'b1, 0);
    issue(2'd1, 3'd0, 8'h0F, acc);
    check("mac_before_rst", {wordline, mac}, {8'h0F, 1'b1});
`endif
    // Asynchronous reset mid-operation
    #2 rst = 1'b1;
    #1;
    check("async_rst_lines", {wordline, bitline, selectline, wenable, form, mac}, 27'h0);
    check("async_rst_rsp", {cmd_ready, rsp_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_rsp_after_abort", rsp_valid, 1'b0);
    end

    // MAC after reset completes normally
    issue(2'd1, 3'd0, 8'h81, acc);
    check("mac2_drive", {wordline, mac}, {8'h81, 1'b1});
    xbar_out = 8'h11;
    @(negedge clk);
    xbar_out = 8'hF0;
    @(negedge clk);
    xbar_out = 8'h00;
    wait_rsp(acc, 3, 8'hF0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
